// File: rtl/circle_raster.sv
// circle_raster: midpoint circle outline rasteriser feeding a linear framebuffer.
//
// A start pulse in IDLE latches the centre, radius and colour. The engine then
// walks the midpoint-circle iterations. Each iteration presents the eight
// symmetric octant pixels, one per cycle (PLOT), and then advances x, y and the
// decision variable (STEP). It finishes with a one-cycle done pulse (DONE).
// Pixels that fall outside the framebuffer still consume their cycle, but
// wr_en stays low for them.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle draw request, honoured only in IDLE
//   cx, cy    in   circle centre (unsigned)
//   radius    in   circle radius (unsigned)
//   color     in   colour index to write
//   wr_stall  in   framebuffer back-pressure; holds a pending write
//   wr_en     out  pixel write strobe
//   wr_addr   out  linear pixel address y*FB_W+x (0 when no write)
//   wr_data   out  colour index (0 when no write)
//   busy      out  high from the cycle after start until the done cycle
//   done      out  one-cycle completion pulse
module circle_raster #(
  parameter int FB_W = 640,
  parameter int FB_H = 480,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    cx,
  input  logic [8:0]    cy,
  input  logic [8:0]    radius,
  input  logic [CW-1:0] color,
  input  logic          wr_stall,
  output logic          wr_en,
  output logic [18:0]   wr_addr,
  output logic [CW-1:0] wr_data,
  output logic          busy,
  output logic          done
);

  localparam logic signed [10:0] FB_W_S = 11'(FB_W);
  localparam logic signed [10:0] FB_H_S = 11'(FB_H);

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_STEP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [9:0]           cx_q, cx_d;
  logic [8:0]           cy_q, cy_d;
  logic [CW-1:0]        color_q, color_d;
  logic signed [10:0]   x_q, x_d;
  logic signed [10:0]   y_q, y_d;
  logic signed [10:0]   d_q, d_d;
  logic [2:0]           oct_q, oct_d;

  // current pixel
  logic signed [10:0]   dx, dy, px, py;
  logic                 visible;
  logic [18:0]          pix_addr;

  // midpoint step candidates
  logic signed [10:0]   y_inc, x_dec, x_step, d_step;

  // Octant offset selection and clipping of the pixel presented this cycle.
  // A cx+x overflow of the 11-bit sum wraps negative and is clipped as off-screen.
  always_comb begin
    dx = x_q;
    dy = y_q;
    case (oct_q)
      3'd0: begin dx =  x_q; dy =  y_q; end
      3'd1: begin dx =  y_q; dy =  x_q; end
      3'd2: begin dx = -y_q; dy =  x_q; end
      3'd3: begin dx = -x_q; dy =  y_q; end
      3'd4: begin dx = -x_q; dy = -y_q; end
      3'd5: begin dx = -y_q; dy = -x_q; end
      3'd6: begin dx =  y_q; dy = -x_q; end
      default: begin dx = x_q; dy = -y_q; end
    endcase
    px       = $signed({1'b0, cx_q}) + dx;
    py       = $signed({2'b00, cy_q}) + dy;
    visible  = !px[10] && (px < FB_W_S) && !py[10] && (py < FB_H_S);
    pix_addr = 19'(py[8:0]) * 19'(FB_W) + 19'(px[9:0]);
  end

  // Midpoint decision update. The "else" branch uses the already-decremented x.
  always_comb begin
    y_inc  = y_q + 11'sd1;
    x_dec  = x_q - 11'sd1;
    x_step = d_q[10] ? x_q : x_dec;
    d_step = d_q[10] ? (d_q + (y_inc <<< 1) + 11'sd1)
                     : (d_q + ((y_inc - x_dec) <<< 1) + 11'sd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      oct_q   <= oct_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    oct_d   = oct_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          color_d = color;
          x_d     = $signed({2'b00, radius});
          y_d     = '0;
          d_d     = 11'sd1 - $signed({2'b00, radius});
          oct_d   = '0;
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        // Only a visible pixel can be stalled; clipped slots always advance.
        if (!(visible && wr_stall)) begin
          if (oct_q == 3'd7) begin
            oct_d   = '0;
            state_d = S_STEP;
          end else begin
            oct_d = oct_q + 3'd1;
          end
        end
      end
      S_STEP: begin
        x_d     = x_step;
        y_d     = y_inc;
        d_d     = d_step;
        oct_d   = '0;
        state_d = (x_step < y_inc) ? S_DONE : S_PLOT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    if (state_q == S_PLOT && visible) begin
      wr_en   = 1'b1;
      wr_addr = pix_addr;
      wr_data = color_q;
    end
  end

endmodule

// File: tb/tb_circle_raster.sv
// Testbench for circle_raster: randomized draws checked against a behavioural
// midpoint-circle model, plus directed cases with hand-computed expectations.
module tb_circle_raster;
  localparam int FB_W = 640;
  localparam int FB_H = 480;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst, start, wr_stall;
  logic [9:0]    cx;
  logic [8:0]    cy, radius;
  logic [CW-1:0] color;
  logic          wr_en, busy, done;
  logic [18:0]   wr_addr;
  logic [CW-1:0] wr_data;

  always #5 clk = ~clk;

  circle_raster #(.FB_W(FB_W), .FB_H(FB_H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy), .radius(radius),
    .color(color), .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int exp_addr[$];
  int exp_data[$];
  int exp_iters = 0;

  // monitor state
  bit ready = 0;
  bit exp_busy = 0;
  bit prev_stall = 0;
  bit after_rst = 0;
  int prev_addr = 0;
  int cyc = 0;
  int start_cyc = 0;
  int stall_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_done_off = 0;

  // stall driver controls
  int stall_pct = 0;
  int force_stall = 0;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Behavioural model: every visible pixel in write order, plus iteration count.
  task automatic build_model(input int cxi, input int cyi, input int ri, input int coli);
    int x, y, d, px, py;
    exp_addr.delete();
    exp_data.delete();
    exp_iters = 0;
    x = ri; y = 0; d = 1 - ri;
    while (1) begin
      exp_iters++;
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cxi + x; py = cyi + y; end
          1: begin px = cxi + y; py = cyi + x; end
          2: begin px = cxi - y; py = cyi + x; end
          3: begin px = cxi - x; py = cyi + y; end
          4: begin px = cxi - x; py = cyi - y; end
          5: begin px = cxi - y; py = cyi - x; end
          6: begin px = cxi + y; py = cyi - x; end
          default: begin px = cxi + x; py = cyi - y; end
        endcase
        if (px >= 0 && px < FB_W && py >= 0 && py < FB_H) begin
          exp_addr.push_back(py * FB_W + px);
          exp_data.push_back(coli);
        end
      end
      y = y + 1;
      if (d < 0) d = d + 2 * y + 1;
      else begin
        x = x - 1;
        d = d + 2 * (y - x) + 1;
      end
      if (x < y) break;
    end
  endtask

  // Stall driver: forced stalls (only once busy) take precedence over random ones.
  initial begin
    wr_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_stall > 0 && busy) begin
        wr_stall = 1'b1;
        force_stall--;
      end else begin
        wr_stall = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
      end
    end
  end

  // Compare process: every cycle, outputs against the model and expected timing.
  always @(negedge clk) begin
    if (ready) begin
      cyc++;
      chk(busy === exp_busy, "busy", int'(busy), int'(exp_busy));
      if (after_rst)
        chk(wr_addr == 0 && wr_data == 0 && done == 1'b0 && wr_en == 1'b0,
            "reset_outputs", int'(wr_addr), 0);
      if (prev_stall && !after_rst)
        chk(wr_en === 1'b1 && int'(wr_addr) == prev_addr, "stall_hold", int'(wr_addr), prev_addr);
      if (wr_en === 1'b1) begin
        chk(exp_busy && exp_addr.size() > 0, "unexpected_write", int'(wr_addr), -1);
        if (exp_busy && exp_addr.size() > 0) begin
          chk(int'(wr_addr) == exp_addr[0], "wr_addr", int'(wr_addr), exp_addr[0]);
          chk(int'(wr_data) == exp_data[0], "wr_data", int'(wr_data), exp_data[0]);
          if (wr_stall) stall_cnt++;
          else begin
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
            acc_cnt++;
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        chk(exp_busy, "done_unexpected", 1, 0);
        if (exp_busy) begin
          chk(exp_addr.size() == 0, "writes_missing_at_done", exp_addr.size(), 0);
          chk(cyc == start_cyc + 1 + 9 * exp_iters + stall_cnt, "done_cycle",
              cyc - start_cyc, 1 + 9 * exp_iters + stall_cnt);
          last_done_off = cyc - start_cyc;
        end
      end
      prev_stall = (wr_en === 1'b1) && (wr_stall === 1'b1);
      prev_addr  = int'(wr_addr);
      after_rst  = rst;
      if (rst) begin
        exp_busy = 0;
        exp_addr.delete();
        exp_data.delete();
      end else if (start && !exp_busy) begin
        exp_busy  = 1;
        start_cyc = cyc;
        stall_cnt = 0;
        acc_cnt   = 0;
      end else if (done) begin
        exp_busy = 0;
      end
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(n < budget, "done_timeout", n, budget);
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int cxi, input int cyi, input int ri, input int coli,
                        input int pct, input int force_n);
    build_model(cxi, cyi, ri, coli);
    @(posedge clk);
    #1;
    cx = 10'(cxi); cy = 9'(cyi); radius = 9'(ri); color = CW'(coli);
    stall_pct = pct; force_stall = force_n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic draw(input int cxi, input int cyi, input int ri, input int coli,
                      input int pct, input int force_n);
    launch(cxi, cyi, ri, coli, pct, force_n);
    wait_done(20000);
  endtask

  initial begin
    int lit37[8];
    int lit38[6];
    int dc, n;
    lit37 = '{32101, 32740, 32740, 32099, 32099, 31460, 31460, 32101};
    lit38 = '{2, 1280, 1280, 2, 642, 1281};

    rst = 1'b1; start = 1'b0; cx = '0; cy = '0; radius = '0; color = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ready = 1;
    @(negedge clk);
    chk(wr_en == 1'b0 && busy == 1'b0 && done == 1'b0, "reset_ctrl", int'(busy), 0);
    chk(wr_addr == 0 && wr_data == 0, "reset_data", int'(wr_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Model pins with hand-computed values
    build_model(100, 50, 1, 2);
    chk(exp_addr.size() == 8 && exp_iters == 1, "model_r1_size", exp_addr.size(), 8);
    for (int i = 0; i < 8; i++)
      chk(exp_addr.size() == 8 && exp_addr[i] == lit37[i], "model_r1_addr",
          (exp_addr.size() == 8) ? exp_addr[i] : -1, lit37[i]);
    build_model(0, 0, 2, 1);
    chk(exp_addr.size() == 6 && exp_iters == 2, "model_r2_size", exp_addr.size(), 6);
    for (int i = 0; i < 6; i++)
      chk(exp_addr.size() == 6 && exp_addr[i] == lit38[i], "model_r2_addr",
          (exp_addr.size() == 6) ? exp_addr[i] : -1, lit38[i]);
    exp_addr.delete();
    exp_data.delete();

    // radius 0: eight writes to 6410, done ten cycles after start
    draw(10, 10, 0, 5, 0, 0);
    chk(acc_cnt == 8, "r0_writes", acc_cnt, 8);
    chk(last_done_off == 10, "r0_done_latency", last_done_off, 10);
    chk(busy == 1'b0, "r0_busy_after", int'(busy), 0);

    // radius 1 at (100,50)
    draw(100, 50, 1, 2, 0, 0);
    chk(acc_cnt == 8, "r1_writes", acc_cnt, 8);
    chk(last_done_off == 10, "r1_done_latency", last_done_off, 10);

    // corner clipping at (0,0)
    draw(0, 0, 2, 7, 0, 0);
    chk(acc_cnt == 6, "corner_writes", acc_cnt, 6);
    chk(last_done_off == 19, "corner_done_latency", last_done_off, 19);

    // three stall cycles on the first write
    draw(100, 50, 1, 2, 0, 3);
    chk(acc_cnt == 8, "stall_writes", acc_cnt, 8);
    chk(stall_cnt == 3, "stall_cycles", stall_cnt, 3);
    chk(last_done_off == 13, "stall_done_latency", last_done_off, 13);

    // randomized draws with random back-pressure
    for (int t = 0; t < 25; t++) begin
      int rcx, rcy, rr, rc, rp;
      rcx = (t % 5 == 0) ? int'($urandom_range(1023)) : int'($urandom_range(FB_W - 1));
      rcy = (t % 7 == 0) ? int'($urandom_range(511)) : int'($urandom_range(FB_H - 1));
      rr  = int'($urandom_range(60));
      rc  = int'($urandom_range(7));
      rp  = int'($urandom_range(40));
      draw(rcx, rcy, rr, rc, rp, 0);
    end
    stall_pct = 0;

    // start while busy is ignored: exactly one done pulse
    dc = done_cnt;
    launch(320, 240, 20, 4, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20000);
    repeat (5) @(posedge clk);
    #1;
    chk(done_cnt == dc + 1, "ignored_start_done_count", done_cnt - dc, 1);

    // reset after 20 accepted writes aborts the draw
    dc = done_cnt;
    launch(320, 240, 20, 6, 0, 0);
    n = 0;
    while (acc_cnt < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 2000, "abort_wait_timeout", n, 2000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk(wr_en == 1'b0 && busy == 1'b0, "abort_idle", int'(busy), 0);
    repeat (300) @(posedge clk);
    #1;
    chk(done_cnt == dc, "abort_no_done", done_cnt - dc, 0);

    // reset wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(busy == 1'b0, "rst_over_start", int'(busy), 0);

    // normal draw after the abort
    draw(320, 240, 20, 3, 20, 0);
    chk(done_cnt == dc + 1, "post_abort_done", done_cnt - dc, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
